// File: rtl/dtb_pkg.sv
// Shared types and sizing for the trace logger front end (trace_packer and helpers).
package dtb_pkg;

  localparam int unsigned TRB_WIDTH       = 64;
  localparam int unsigned TRB_NTRACE_BITS = 3;
  localparam int unsigned TRB_LG          = $clog2(TRB_WIDTH);
  localparam int unsigned LG_W            = $clog2(TRB_LG + 1);
  localparam int unsigned DROP_CNT_W      = 16;

  typedef enum logic [1:0] {
    ARMED,
    TRIGGERED,
    STOPPED
  } packer_state_t;

  typedef struct packed {
    logic [TRB_WIDTH-1:0] data;
    logic                 evt;
    logic [TRB_LG-1:0]    pos;
  } trace_word_t;

  // log2 of the sample width, clamped so a sample never exceeds one word
  function automatic logic [LG_W-1:0] clamp_lg(input logic [TRB_NTRACE_BITS-1:0] n);
    if (32'(n) > TRB_LG) return LG_W'(TRB_LG);
    return LG_W'(n);
  endfunction

  // low 2**lg bits set
  function automatic logic [TRB_WIDTH-1:0] lane_mask(input logic [LG_W-1:0] lg);
    logic [TRB_WIDTH-1:0] m;
    m = '1;
    if (32'(lg) < TRB_LG) m = (TRB_WIDTH'(1) << (32'(1) << lg)) - TRB_WIDTH'(1);
    return m;
  endfunction

endpackage

// File: rtl/trace_packer_word_reg.sv
// One-deep output register: loads a completed word when free or draining, otherwise flags a drop.
module trace_word_reg
  import dtb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  trace_word_t word_in,
  input  logic        store_perm,
  output trace_word_t word_out,
  output logic        store,
  output logic        drop_c
);

  logic transfer_c;
  logic take_c;

  assign transfer_c = store & store_perm;
  assign take_c     = load & (~store | store_perm);
  assign drop_c     = load & store & ~store_perm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store    <= 1'b0;
      word_out <= '0;
    end else if (take_c) begin
      store    <= 1'b1;
      word_out <= word_in;
    end else if (transfer_c) begin
      store    <= 1'b0;
    end
  end

endmodule

// File: rtl/trace_packer.sv
// Packs 2**n-bit trace samples LSB-first into TRB_WIDTH-bit words with trigger tagging.
// Optional TRACE_PACKER_DROP_CNT_EN adds a saturating dropped-word counter on DROP_CNT_O.
module trace_packer
  import dtb_pkg::*;
(
  input  logic                       CLK_I,
  input  logic                       RST_I,
  input  logic [TRB_WIDTH-1:0]       TRACE_I,
  input  logic                       TRACE_VALID_I,
  input  logic                       TRG_I,
  input  logic                       MODE_I,
  input  logic [TRB_NTRACE_BITS-1:0] NTRACE_I,
  input  logic                       TRG_DELAYED_I,
  output logic [TRB_WIDTH-1:0]       DATA_O,
  output logic                       STORE_O,
  input  logic                       STORE_PERM_I,
  output logic                       TRG_EVENT_O,
  output logic [TRB_LG-1:0]          EVENT_POS_O,
`ifdef TRACE_PACKER_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0]      DROP_CNT_O,
`endif
  output logic                       OVF_O
);

  packer_state_t        state_q, state_d;
  logic [TRB_LG-1:0]    fill_q;
  logic [LG_W-1:0]      lg_q;
  logic [TRB_WIDTH-1:0] pack_q;
  logic                 evt_q;
  logic [TRB_LG-1:0]    evt_pos_q;
  logic                 ovf_q;

  logic                 accept_c;
  logic                 trig_c;
  logic                 complete_c;
  logic                 drop_c;
  logic [LG_W-1:0]      lg_c;
  logic [TRB_LG-1:0]    step_c;
  logic [TRB_LG-1:0]    fill_sum_c;
  trace_word_t          word_c;
  trace_word_t          word_q;

  // Width is relatched only at a word boundary; a full-width step wraps to 0.
  always_comb begin
    accept_c    = TRACE_VALID_I && (state_q != STOPPED);
    lg_c        = (fill_q == '0) ? clamp_lg(NTRACE_I) : lg_q;
    step_c      = TRB_LG'(1) << lg_c;
    fill_sum_c  = fill_q + step_c;
    trig_c      = accept_c && TRG_I && (state_q == ARMED);
    complete_c  = accept_c && (fill_sum_c == '0);
    word_c.data = pack_q | ((TRACE_I & lane_mask(lg_c)) << fill_q);
    word_c.evt  = evt_q | trig_c;
    word_c.pos  = trig_c ? fill_q : evt_pos_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED:     if (trig_c) state_d = TRIGGERED;
      TRIGGERED: if (TRG_DELAYED_I && !MODE_I) state_d = STOPPED;
      default:   state_d = state_q;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state_q <= ARMED;
    else       state_q <= state_d;
  end

  // Pack register; STOPPED discards whatever partial word remains.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      fill_q    <= '0;
      lg_q      <= '0;
      pack_q    <= '0;
      evt_q     <= 1'b0;
      evt_pos_q <= '0;
    end else if (state_q == STOPPED) begin
      fill_q    <= '0;
      pack_q    <= '0;
      evt_q     <= 1'b0;
    end else if (accept_c) begin
      lg_q <= lg_c;
      if (complete_c) begin
        fill_q <= '0;
        pack_q <= '0;
        evt_q  <= 1'b0;
      end else begin
        fill_q    <= fill_sum_c;
        pack_q    <= word_c.data;
        evt_q     <= word_c.evt;
        evt_pos_q <= word_c.pos;
      end
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I)       ovf_q <= 1'b0;
    else if (drop_c) ovf_q <= 1'b1;
  end

`ifdef TRACE_PACKER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I)                          drop_cnt_q <= '0;
    else if (drop_c && ~&drop_cnt_q)    drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
  end

  assign DROP_CNT_O = drop_cnt_q;
`endif

  trace_word_reg u_word_reg (
    .clk        (CLK_I),
    .rst        (RST_I),
    .load       (complete_c),
    .word_in    (word_c),
    .store_perm (STORE_PERM_I),
    .word_out   (word_q),
    .store      (STORE_O),
    .drop_c     (drop_c)
  );

  assign DATA_O      = word_q.data;
  assign TRG_EVENT_O = word_q.evt;
  assign EVENT_POS_O = word_q.pos;
  assign OVF_O       = ovf_q;

endmodule

// File: tb/tb_trace_packer.sv
// Self-checking bench for trace_packer: directed scenarios plus randomized traffic vs a word-level model.
module tb_trace_packer;
  import dtb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] trace;
  logic        valid, trg, mode, dly, perm;
  logic [2:0]  ntrace;
  logic [63:0] data;
  logic        store, evt, ovf;
  logic [5:0]  pos;
`ifdef TRACE_PACKER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  trace_packer dut (
    .CLK_I         (clk),
    .RST_I         (rst),
    .TRACE_I       (trace),
    .TRACE_VALID_I (valid),
    .TRG_I         (trg),
    .MODE_I        (mode),
    .NTRACE_I      (ntrace),
    .TRG_DELAYED_I (dly),
    .DATA_O        (data),
    .STORE_O       (store),
    .STORE_PERM_I  (perm),
    .TRG_EVENT_O   (evt),
    .EVENT_POS_O   (pos),
`ifdef TRACE_PACKER_DROP_CNT_EN
    .DROP_CNT_O    (drop_cnt),
`endif
    .OVF_O         (ovf)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Word-level reference: state 0=armed 1=triggered 2=stopped, bits accumulate by arithmetic offset.
  int          m_state, m_fill, m_lg, m_pos, m_opos, m_drops;
  logic [63:0] m_word, m_out;
  bit          m_evt, m_sv, m_oevt, m_ovf;

  task automatic model_reset();
    m_state = 0; m_fill = 0; m_lg = 0; m_pos = 0; m_opos = 0; m_drops = 0;
    m_word = '0; m_out = '0; m_evt = 0; m_sv = 0; m_oevt = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    int          old_state;
    int          w;
    logic [63:0] smp;
    old_state = m_state;
    if (m_sv && perm) m_sv = 0;
    if (valid && old_state != 2) begin
      if (m_fill == 0) m_lg = (int'(ntrace) > 6) ? 6 : int'(ntrace);
      w   = 1 << m_lg;
      smp = (w == 64) ? trace : trace % (64'd1 << w);
      if (trg && old_state == 0) begin
        m_evt = 1; m_pos = m_fill; m_state = 1;
      end
      m_word = m_word | (smp << m_fill);
      m_fill = m_fill + w;
      if (m_fill == 64) begin
        if (!m_sv) begin
          m_sv = 1; m_out = m_word; m_oevt = m_evt; m_opos = m_pos;
        end else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
        m_word = '0; m_fill = 0; m_evt = 0;
      end
    end
    if (old_state == 1 && dly && !mode) m_state = 2;
    if (old_state == 2) begin
      m_word = '0; m_fill = 0; m_evt = 0;
    end
  endtask

  task automatic compare(input string tag);
    check({tag, ".store"}, 64'(store), 64'(m_sv));
    if (m_sv) begin
      check({tag, ".data"}, data, m_out);
      check({tag, ".evt"}, 64'(evt), 64'(m_oevt));
      if (m_oevt) check({tag, ".pos"}, 64'(pos), 64'(m_opos));
    end
    check({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
`ifdef TRACE_PACKER_DROP_CNT_EN
    check({tag, ".drops"}, 64'(drop_cnt), 64'(m_drops));
`endif
  endtask

  // Drive one cycle's inputs (called at a negedge), advance the model, check after the posedge.
  task automatic cycle(input bit v, input logic [63:0] t, input bit g, input bit md,
                       input int n, input bit d, input bit p, input string tag);
    valid = v; trace = t; trg = g; mode = md; ntrace = 3'(n); dly = d; perm = p;
    model_step();
    @(negedge clk);
    compare(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 0; trace = '0; trg = 0; mode = 0; ntrace = '0; dly = 0; perm = 0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    compare("rst");
    rst = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  logic [63:0] w1;
  int          rn;

  initial begin
    do_reset();
    check("rst.data", data, 64'd0);
    check("rst.evt", 64'(evt), 64'd0);
    check("rst.pos", 64'(pos), 64'd0);

    // bytes 0x01..0x08 form one word, visible one cycle after the 8th sample
    for (int i = 1; i <= 8; i++) cycle(1, 64'(i), 0, 0, 3, 0, 1, "byte");
    check("byte.store_now", 64'(store), 64'd1);
    check("byte.word", data, 64'h0807060504030201);
    cycle(0, '0, 0, 0, 3, 0, 1, "byte");

    // nibble samples, trigger on the 6th -> bit offset 20
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, rnd64(), i == 5, 1, 2, 0, 1, "trgpos");
    check("trgpos.evt", 64'(evt), 64'd1);
    check("trgpos.pos", 64'(pos), 64'd20);
    for (int i = 0; i < 16; i++) cycle(1, rnd64(), 0, 1, 2, 0, 1, "trgpos2");
    check("trgpos2.store", 64'(store), 64'd1);
    check("trgpos2.evt", 64'(evt), 64'd0);

    // backpressure: word 1 held, words 2 and 3 dropped
    do_reset();
    w1 = rnd64();
    cycle(1, w1, 0, 1, 6, 0, 0, "bp");
    cycle(1, rnd64(), 0, 1, 6, 0, 0, "bp");
    check("bp.hold1", data, w1);
    cycle(1, rnd64(), 0, 1, 6, 0, 0, "bp");
    check("bp.hold2", data, w1);
    check("bp.ovf", 64'(ovf), 64'd1);
`ifdef TRACE_PACKER_DROP_CNT_EN
    check("bp.dropcnt", 64'(drop_cnt), 64'd2);
`endif
    cycle(0, '0, 0, 1, 6, 0, 1, "bp");
    cycle(0, '0, 0, 1, 6, 0, 1, "bp");

    // full-width words every cycle with permission: no drops
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1, rnd64(), 0, 1, 6, 0, 1, "stream");
    check("stream.store", 64'(store), 64'd1);
    check("stream.ovf", 64'(ovf), 64'd0);

    // stop vs continuous with the same stimulus
    for (int md = 0; md < 2; md++) begin
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1, rnd64(), i == 0, md[0], 3, 0, 0, "stop");
      for (int i = 0; i < 3; i++) cycle(1, rnd64(), 0, md[0], 3, 0, 0, "stop");
      cycle(0, '0, 0, md[0], 3, 1, 0, "stop");
      for (int i = 0; i < 5; i++) cycle(1, rnd64(), 0, md[0], 3, 0, 1, "stop");
      check(md == 0 ? "stop.nostore" : "cont.store", 64'(store), md == 0 ? 64'd0 : 64'd1);
      for (int i = 0; i < 10; i++) cycle(1, rnd64(), 0, md[0], 3, 0, 1, "stop");
    end

    // asynchronous reset while a word is pending
    do_reset();
    cycle(1, rnd64(), 0, 0, 6, 0, 0, "arst");
    #2 rst = 1'b1;
    #1;
    check("arst.store", 64'(store), 64'd0);
    check("arst.data", data, 64'd0);
    check("arst.evt", 64'(evt), 64'd0);
    check("arst.ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 8; i++) cycle(1, 64'(i * 17), i == 2, 0, 3, 0, 1, "arst");
    check("arst.restart", data, 64'h8877665544332211);
    check("arst.evt_pos", 64'(pos), 64'd8);

    // randomized traffic in both modes
    for (int md = 0; md < 2; md++) begin
      rn = 3;
      for (int blk = 0; blk < 8; blk++) begin
        do_reset();
        for (int i = 0; i < 180; i++) begin
          if ($urandom_range(0, 7) == 0) rn = $urandom_range(0, 7);
          cycle($urandom_range(0, 3) != 0, rnd64(), $urandom_range(0, 15) == 0, md[0], rn,
                $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, "rand");
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule

// File: doc/trace_packer.md
# trace_packer

Upstream stage of the trace logger. Packs narrow per-cycle trace samples (1 to TRB_WIDTH bits wide, selected by the logger's NTRACE setting) LSB-first into TRB_WIDTH-bit words. It hands each completed word to the logger over a store/permission handshake, tagging it with the trigger event and the bit position of the triggering sample. It stops capture once the logger reports the delayed trigger.

## Interface
- TRB_WIDTH, 64, packed word width; power of two.
- TRB_NTRACE_BITS, 3, width of NTRACE_I.
- CLK_I  in  1  clock.
- RST_I  in  1  reset, asynchronous, active-high.
- TRACE_I  in  TRB_WIDTH  sample; only the low 2**n bits are used.
- TRACE_VALID_I  in  1  sample strobe.
- TRG_I  in  1  trigger condition, qualified by TRACE_VALID_I.
- MODE_I  in  1  0 = stop after delayed trigger, 1 = continuous streaming.
- NTRACE_I  in  TRB_NTRACE_BITS  n; sample width is 2**n bits, clamped to log2(TRB_WIDTH).
- TRG_DELAYED_I  in  1  delayed-trigger indication from the logger.
- DATA_O  out  TRB_WIDTH  packed word.
- STORE_O  out  1  word valid.
- STORE_PERM_I  in  1  logger accepts the word.
- TRG_EVENT_O  out  1  the word on DATA_O contains the trigger sample.
- EVENT_POS_O  out  log2(TRB_WIDTH)  bit offset of the trigger sample in DATA_O.
- OVF_O  out  1  sticky: a completed word was dropped.
- DROP_CNT_O  out  16  dropped-word count; present only with TRACE_PACKER_DROP_CNT_EN.

## Operation
- Reset values of all outputs are 0. Fill pointer is 0, state is ARMED, and the pack register is cleared.
- Sample width w = 2**min(NTRACE_I, log2(TRB_WIDTH)).
  - w is latched on the accept when fill = 0.
  - Changes to NTRACE_I mid-word are ignored until the next word boundary.
- Accept condition: TRACE_VALID_I high and state ≠ STOPPED.
  - On accept, TRACE_I[w-1:0] is written at bits [fill+w-1:fill].
  - fill advances by w, computed modulo TRB_WIDTH.
  - The word is complete when fill wraps to 0.
- Trigger capture:
  - An accepted sample with TRG_I high in state ARMED records evt_pos = fill and evt = 1, and moves the state to TRIGGERED.
  - Later triggers are ignored.
- The output register is one word deep; DATA_O, TRG_EVENT_O and EVENT_POS_O travel together.
  - Transfer occurs when STORE_O && STORE_PERM_I.
  - While STORE_O is high and no transfer occurs, the outputs are held stable.
- Word completion:
  - If the output register is empty, or a transfer happens in the same cycle, the word is loaded and STORE_O is high next cycle.
  - Otherwise the word and its trigger tag are dropped. OVF_O is set and the state still advances to TRIGGERED.
- States:
  - ARMED → TRIGGERED on the trigger sample.
  - TRIGGERED → STOPPED on TRG_DELAYED_I=1 when MODE_I=0.
  - In MODE_I=1, TRG_DELAYED_I is ignored.
  - In STOPPED, no samples are accepted and the partial word is discarded. A pending output word is still delivered.
  - STOPPED is left only by reset.
- If a pack register lane and its w differ across a reset, reset wins: all state is cleared immediately, including the pending word.

## Timing
- Latency is 1 cycle from the accept that completes a word to STORE_O high.
- Back-to-back full words at n = log2(TRB_WIDTH) give one word per cycle, provided STORE_PERM_I stays high.
- TRG_DELAYED_I and an accept in the same cycle: the accept still occurs. STOPPED takes effect the next cycle.
- A word completes in the same cycle TRG_DELAYED_I rises: the word is still loaded or dropped normally.
- The OVF_O set is visible the cycle after the drop.

## Configuration
- TRACE_PACKER_DROP_CNT_EN:
  - Defined: adds DROP_CNT_O, a 16-bit counter incremented on each drop. It saturates at 0xFFFF and resets to 0.
  - Undefined: the port and counter are absent; only OVF_O reports drops.

## Structure
- DTB_PKG holds TRB_WIDTH, TRB_NTRACE_BITS, and the enum packer_state_t {ARMED, TRIGGERED, STOPPED}.
- Sub-module trace_word_reg: one-deep output register with the load/hold/transfer/drop decision; it emits the drop pulse.
- The top level holds the pack register, fill pointer, width latch and FSM.

## Test plan
- Byte packing: TRB_WIDTH=64, n=3, 8 valid samples 0x01..0x08, STORE_PERM_I=1 → one STORE_O with DATA_O=0x0807060504030201, 1 cycle after the 8th sample.
- Trigger position: n=2, 64-bit word, TRG_I on the 6th sample → TRG_EVENT_O=1 with EVENT_POS_O=20 on that word; the next word has TRG_EVENT_O=0.
- Backpressure/drop: n=6, TRACE_VALID_I every cycle, STORE_PERM_I=0 for 3 cycles:
  - word 1 is held stable;
  - words 2 and 3 are dropped;
  - OVF_O=1;
  - DROP_CNT_O=2 with the macro defined.
- Simultaneous complete and transfer: n=6, continuous, STORE_PERM_I=1 → STORE_O high every cycle, no drop, OVF_O=0.
- Stop: MODE_I=0, trigger, then TRG_DELAYED_I pulse with 3 of 8 bytes filled → the pending word is delivered, the partial word is discarded, no further STORE_O. MODE_I=1 with the same stimulus → packing continues.
- Reset mid-word: RST_I asserted asynchronously with STORE_O=1 → all outputs 0 immediately. After release, packing restarts at fill=0 and the state is ARMED.
